// File: rtl/pr_bridge_pkg.sv
// pr_bridge_pkg: shared types and constants for the peripheral bridge.
// State encoding, default device window bases and device index constants.
package pr_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } pr_state_e;

  localparam logic [31:0] DEV0_BASE_DEF = 32'h0000_7F00;
  localparam logic [31:0] DEV1_BASE_DEF = 32'h0000_7F10;

  // Window spans three words: offsets 0x0, 0x4 and 0x8.
  localparam logic [31:0] WIN_LAST_OFS = 32'h0000_0008;

  localparam logic DEV0_IDX = 1'b0;
  localparam logic DEV1_IDX = 1'b1;

endpackage

// File: rtl/pr_addr_dec.sv
// pr_addr_dec: combinational decoder of the CPU word address into the two
// three-word device windows plus the word offset inside a window.
import pr_bridge_pkg::*;

module pr_addr_dec #(
  parameter logic [31:0] DEV0_BASE = DEV0_BASE_DEF,
  parameter logic [31:0] DEV1_BASE = DEV1_BASE_DEF
) (
  input  logic [29:0] cpu_addr,
  output logic        hit0,
  output logic        hit1,
  output logic [1:0]  dev_addr
);

  logic [31:0] byte_addr;

  // Window compare on the byte address; offset 0xC falls outside both windows.
  always_comb begin
    byte_addr = {cpu_addr, 2'b00};
    hit0      = (byte_addr >= DEV0_BASE) && (byte_addr <= DEV0_BASE + WIN_LAST_OFS);
    hit1      = (byte_addr >= DEV1_BASE) && (byte_addr <= DEV1_BASE + WIN_LAST_OFS);
    dev_addr  = cpu_addr[1:0];
  end

endmodule

// File: rtl/pr_bridge_ctrl.sv
// pr_bridge_ctrl: sequences CPU peripheral-port accesses to timer0/timer1,
// stalls the CPU until the device acknowledges, maps device interrupts onto
// HWint[7:2] and keeps a sticky flag for unmapped accesses.
// Optional macro PR_BRIDGE_TIMEOUT_EN: bounds the ACCESS wait to TIMEOUT
// cycles, after which the access completes through ERR.
//
// state  | meaning
// IDLE   | waiting for cpu_req; decode and capture the access
// ACCESS | dev_req asserted to the selected device, waiting for its ack
// DONE   | cpu_ready pulse with read data (0 for writes)
// ERR    | cpu_ready pulse with zero data, bus_err gets set
import pr_bridge_pkg::*;

module pr_bridge_ctrl #(
  parameter logic [31:0] DEV0_BASE = DEV0_BASE_DEF,
  parameter logic [31:0] DEV1_BASE = DEV1_BASE_DEF
`ifdef PR_BRIDGE_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [29:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic [1:0]  dev_req,
  output logic        dev_we,
  output logic [1:0]  dev_addr,
  output logic [31:0] dev_wdata,
  input  logic [1:0]  dev_ack,
  input  logic [31:0] dev_rdata0,
  input  logic [31:0] dev_rdata1,
  input  logic [1:0]  dev_irq,
  output logic [5:0]  hwint,
  output logic        bus_err,
  input  logic        err_clr
);

  pr_state_e  state;
  logic       sel;
  logic       hit0;
  logic       hit1;
  logic [1:0] dec_addr;

`ifdef PR_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] cnt;
`endif

  pr_addr_dec #(
    .DEV0_BASE (DEV0_BASE),
    .DEV1_BASE (DEV1_BASE)
  ) u_dec (
    .cpu_addr (cpu_addr),
    .hit0     (hit0),
    .hit1     (hit1),
    .dev_addr (dec_addr)
  );

  // Access FSM; every CPU- and device-facing output is a register of this block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      sel       <= DEV0_IDX;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      dev_req   <= '0;
      dev_we    <= 1'b0;
      dev_addr  <= '0;
      dev_wdata <= '0;
`ifdef PR_BRIDGE_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            if (hit0 || hit1) begin
              state     <= ST_ACCESS;
              sel       <= hit1 ? DEV1_IDX : DEV0_IDX;
              dev_req   <= hit1 ? 2'b10 : 2'b01;
              dev_we    <= cpu_we;
              dev_addr  <= dec_addr;
              dev_wdata <= cpu_wdata;
`ifdef PR_BRIDGE_TIMEOUT_EN
              cnt       <= '0;
`endif
            end else begin
              state     <= ST_ERR;
              cpu_ready <= 1'b1;
              cpu_rdata <= '0;
            end
          end
        end
        ST_ACCESS: begin
          // dev_we still holds the captured direction while in ACCESS.
          if (dev_ack[sel]) begin
            state     <= ST_DONE;
            dev_req   <= '0;
            dev_we    <= 1'b0;
            cpu_ready <= 1'b1;
            cpu_rdata <= dev_we ? 32'h0 : ((sel == DEV1_IDX) ? dev_rdata1 : dev_rdata0);
          end
`ifdef PR_BRIDGE_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state     <= ST_ERR;
            dev_req   <= '0;
            dev_we    <= 1'b0;
            cpu_ready <= 1'b1;
            cpu_rdata <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          cpu_ready <= 1'b0;
          state     <= ST_IDLE;
        end
        ST_ERR: begin
          cpu_ready <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          cpu_ready <= 1'b0;
          dev_req   <= '0;
          dev_we    <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky error flag; a set in ERR overrides a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err <= 1'b0;
    end else if (state == ST_ERR) begin
      bus_err <= 1'b1;
    end else if (err_clr) begin
      bus_err <= 1'b0;
    end
  end

  // Interrupt aggregation onto HWint[7:2], independent of the access FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hwint <= '0;
    end else begin
      hwint <= {4'b0000, dev_irq};
    end
  end

endmodule

// File: tb/tb_pr_bridge_ctrl.sv
// tb_pr_bridge_ctrl: directed bench for pr_bridge_ctrl. Inputs change and
// outputs are sampled on the falling clock edge.
`timescale 1ns/1ps

module tb_pr_bridge_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic [1:0]  dev_req;
  logic        dev_we;
  logic [1:0]  dev_addr;
  logic [31:0] dev_wdata;
  logic [1:0]  dev_ack;
  logic [31:0] dev_rdata0;
  logic [31:0] dev_rdata1;
  logic [1:0]  dev_irq;
  logic [5:0]  hwint;
  logic        bus_err;
  logic        err_clr;

  int n_checks = 0;
  int n_errors = 0;

  pr_bridge_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ready  (cpu_ready),
    .dev_req    (dev_req),
    .dev_we     (dev_we),
    .dev_addr   (dev_addr),
    .dev_wdata  (dev_wdata),
    .dev_ack    (dev_ack),
    .dev_rdata0 (dev_rdata0),
    .dev_rdata1 (dev_rdata1),
    .dev_irq    (dev_irq),
    .hwint      (hwint),
    .bus_err    (bus_err),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drives one access starting at a falling edge with the FSM in IDLE.
  // exp_req = 0 means the address is unmapped and ERR is expected.
  // Ends at the falling edge where cpu_ready must be high; cpu_req still high.
  task automatic run_access(input logic [31:0] baddr, input logic we, input logic [31:0] wdata,
                            input int waits, input logic [1:0] exp_req, input logic [31:0] rd,
                            input logic clr_in_err);
    logic [31:0] exp_rdata;
    exp_rdata  = (we || exp_req == 2'b00) ? 32'h0 : rd;
    cpu_req    = 1'b1;
    cpu_we     = we;
    cpu_addr   = baddr[31:2];
    cpu_wdata  = wdata;
    dev_ack    = 2'b00;
    dev_rdata0 = (exp_req == 2'b01) ? rd : 32'h0BAD_0000;
    dev_rdata1 = (exp_req == 2'b10) ? rd : 32'h0BAD_1111;
    @(negedge clk);
    if (exp_req != 2'b00) begin
      for (int i = 0; i <= waits; i++) begin
        chk("acc_dev_req", 32'(dev_req), 32'(exp_req));
        chk("acc_dev_we", 32'(dev_we), 32'(we));
        chk("acc_dev_addr", 32'(dev_addr), 32'(baddr[3:2]));
        if (we) chk("acc_dev_wdata", dev_wdata, wdata);
        chk("acc_no_ready", 32'(cpu_ready), 32'h0);
        // Scramble the CPU side; the captured copy must be used.
        cpu_addr  = ~baddr[31:2];
        cpu_wdata = ~wdata;
        cpu_we    = ~we;
        dev_ack   = (i == waits) ? exp_req : ~exp_req;
        @(negedge clk);
      end
      dev_ack = 2'b00;
    end else begin
      chk("err_dev_req", 32'(dev_req), 32'h0);
    end
    chk("ready", 32'(cpu_ready), 32'h1);
    chk("rdata", cpu_rdata, exp_rdata);
    chk("end_dev_req", 32'(dev_req), 32'h0);
    chk("end_dev_we", 32'(dev_we), 32'h0);
    if (exp_req == 2'b00) err_clr = clr_in_err;
  endtask

  task automatic release_req();
    cpu_req = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ready_pulse_end", 32'(cpu_ready), 32'h0);
    chk("idle_dev_req", 32'(dev_req), 32'h0);
  endtask

  initial begin
    rst        = 1'b0;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    dev_ack    = 2'b00;
    dev_rdata0 = '0;
    dev_rdata1 = '0;
    dev_irq    = 2'b00;
    err_clr    = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_ready", 32'(cpu_ready), 32'h0);
    chk("rst_dev_req", 32'(dev_req), 32'h0);
    chk("rst_dev_we", 32'(dev_we), 32'h0);
    chk("rst_dev_addr", 32'(dev_addr), 32'h0);
    chk("rst_dev_wdata", dev_wdata, 32'h0);
    chk("rst_hwint", 32'(hwint), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Read dev0 offset 4, ack in first ACCESS cycle
    run_access(32'h0000_7F04, 1'b0, 32'h0, 0, 2'b01, 32'hDEAD_BEEF, 1'b0);
    release_req();

    // Write dev1 offset 8, three wait cycles (non-selected ack during waits)
    run_access(32'h0000_7F18, 1'b1, 32'h0000_0009, 3, 2'b10, 32'h1234_5678, 1'b0);
    release_req();

    // Read dev1 offset 0
    run_access(32'h0000_7F10, 1'b0, 32'h0, 1, 2'b10, 32'hCAFE_0001, 1'b0);
    release_req();
    chk("bus_err_clean", 32'(bus_err), 32'h0);

    // Unmapped offset 0xC in dev0 window
    run_access(32'h0000_7F0C, 1'b0, 32'h0, 0, 2'b00, 32'h0, 1'b0);
    release_req();
    chk("bus_err_set", 32'(bus_err), 32'h1);

    // Clear pulse
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("bus_err_clr", 32'(bus_err), 32'h0);

    // Unmapped 0x7F20 with err_clr during ERR: set wins
    run_access(32'h0000_7F20, 1'b1, 32'h5555_AAAA, 0, 2'b00, 32'h0, 1'b1);
    release_req();
    chk("bus_err_set_wins", 32'(bus_err), 32'h1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("bus_err_clr2", 32'(bus_err), 32'h0);

    // Back-to-back: request held through completion, one IDLE cycle between
    run_access(32'h0000_7F08, 1'b0, 32'h0, 2, 2'b01, 32'h0000_00A5, 1'b0);
    cpu_we   = 1'b1;
    cpu_addr = 30'(32'h0000_7F14 >> 2);
    @(negedge clk);
    chk("b2b_idle_ready", 32'(cpu_ready), 32'h0);
    chk("b2b_idle_req", 32'(dev_req), 32'h0);
    run_access(32'h0000_7F14, 1'b1, 32'hFEED_F00D, 0, 2'b10, 32'h7777_7777, 1'b0);
    release_req();

`ifdef PR_BRIDGE_TIMEOUT_EN
    // Ack on the 16th ACCESS cycle still completes normally
    run_access(32'h0000_7F00, 1'b0, 32'h0, 15, 2'b01, 32'h0F0F_0F0F, 1'b0);
    release_req();
    chk("to_ack_bus_err", 32'(bus_err), 32'h0);

    // No ack: forced ERR after 16 ACCESS cycles
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 30'(32'h0000_7F04 >> 2);
    dev_rdata0 = 32'h1111_2222;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      chk("to_dev_req", 32'(dev_req), 32'h1);
      chk("to_no_ready", 32'(cpu_ready), 32'h0);
      @(negedge clk);
    end
    chk("to_ready", 32'(cpu_ready), 32'h1);
    chk("to_rdata", cpu_rdata, 32'h0);
    chk("to_dev_req_drop", 32'(dev_req), 32'h0);
    release_req();
    chk("to_bus_err", 32'(bus_err), 32'h1);
`else
    // Without the timeout, ACCESS waits indefinitely for the ack
    run_access(32'h0000_7F00, 1'b0, 32'h0, 20, 2'b01, 32'h0F0F_0F0F, 1'b0);
    release_req();
    chk("long_wait_bus_err", 32'(bus_err), 32'h0);
`endif

    // Interrupt aggregation
    dev_irq = 2'b10;
    #1;
    chk("hwint_not_yet", 32'(hwint), 32'h0);
    @(negedge clk);
    chk("hwint_irq1", 32'(hwint), 32'h02);
    dev_irq = 2'b01;
    @(negedge clk);
    chk("hwint_irq0", 32'(hwint), 32'h01);
    dev_irq = 2'b00;
    @(negedge clk);
    chk("hwint_none", 32'(hwint), 32'h0);

    // Reset during ACCESS
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 30'(32'h0000_7F04 >> 2);
    @(negedge clk);
    chk("pre_rst_dev_req", 32'(dev_req), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_dev_req", 32'(dev_req), 32'h0);
    chk("rst_async_ready", 32'(cpu_ready), 32'h0);
    cpu_req = 1'b0;
    dev_ack = 2'b01;
    @(negedge clk);
    dev_ack = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(cpu_ready), 32'h0);
    chk("post_rst_dev_req", 32'(dev_req), 32'h0);

    // Bridge still functional after reset
    run_access(32'h0000_7F04, 1'b0, 32'h0, 0, 2'b01, 32'h0BEE_F000, 1'b0);
    release_req();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pr_bridge_ctrl.md
Name: pr_bridge_ctrl

Overview:
Sequencing bridge between the multicycle CPU's peripheral port (Praddr/PrDin/PrDout/WEcpu side) and two memory-mapped devices (dev0 = timer0, dev1 = timer1). Decodes the word address, runs a request/acknowledge access FSM towards the selected device, and stalls the CPU until completion. Also aggregates device interrupts into the CPU's HWint[7:2] vector, and flags accesses to unmapped peripheral addresses.

Parameters:
DEV0_BASE, 32'h0000_7F00, byte base of dev0 window (3 words: 0x00/0x04/0x08)
DEV1_BASE, 32'h0000_7F10, byte base of dev1 window (3 words)
TIMEOUT, 16, max ACCESS cycles before forced completion (TIMEOUT_EN only)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
cpu_req  in  1  CPU access request; level, held until cpu_ready seen
cpu_we  in  1  1 = write, 0 = read; valid with cpu_req
cpu_addr  in  30  word address [31:2]
cpu_wdata  in  32  write data
cpu_rdata  out  32  read data; valid when cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
dev_req  out  2  per-device request, one-hot
dev_we  out  1  write strobe qualifier, shared
dev_addr  out  2  word offset inside device window
dev_wdata  out  32  captured write data
dev_ack  in  2  per-device acknowledge
dev_rdata0  in  32  dev0 read data, valid with dev_ack[0]
dev_rdata1  in  32  dev1 read data, valid with dev_ack[1]
dev_irq  in  2  device interrupt levels
hwint  out  6  HWint[7:2] to CP0
bus_err  out  1  sticky error flag
err_clr  in  1  synchronous clear of bus_err

Behaviour:
- Reset (rst=0, async): state IDLE; cpu_rdata=0, cpu_ready=0, dev_req=0, dev_we=0, dev_addr=0, dev_wdata=0, hwint=0, bus_err=0, timeout counter=0.
- Decode: hit0 when {cpu_addr,2'b00} in [DEV0_BASE, DEV0_BASE+8]; hit1 likewise for DEV1_BASE; dev_addr = cpu_addr[3:2]. Offset 0xC in a window is unmapped.
- FSM states IDLE, ACCESS, DONE, ERR:
  - IDLE: cpu_req=1 and hit -> ACCESS; capture sel, cpu_we, dev_addr, cpu_wdata. cpu_req=1 and no hit -> ERR. Else stay.
  - ACCESS: dev_req[sel]=1, dev_we=captured we. dev_ack[sel]=1 -> DONE; read: cpu_rdata <= dev_rdataN, write: cpu_rdata <= 0. dev_ack on the non-selected bit ignored.
  - DONE: cpu_ready=1 one cycle, dev_req=0 -> IDLE.
  - ERR: cpu_ready=1 one cycle, cpu_rdata=0, bus_err <= 1 -> IDLE. No device sees a request.
- Outputs registered; dev_req, dev_we low in all states except ACCESS.
- Latency: ack in first ACCESS cycle -> cpu_ready 2 cycles after the cycle cpu_req is sampled in IDLE; each extra wait cycle adds 1.
- CPU must drop cpu_req the cycle after cpu_ready; req still high in IDLE is a new access (back-to-back legal, no bubble beyond IDLE cycle).
- cpu_addr/cpu_we/cpu_wdata changes during ACCESS ignored (captured copy used).
- hwint: registered one cycle; hwint[0] (HWint2) = dev_irq[0], hwint[1] = dev_irq[1], hwint[5:2] = 0. Independent of FSM state.
- bus_err: set in ERR; err_clr=1 clears; same-cycle set and clear -> set wins.
- Reset mid-ACCESS: immediate return to IDLE, dev_req dropped, no cpu_ready.

Optional Feature:
PR_BRIDGE_TIMEOUT_EN defined: counter increments each ACCESS cycle, cleared on entry; reaching TIMEOUT-1 without ack -> ERR (dev_req dropped, bus_err set, cpu_rdata=0). Ack on that same cycle wins (-> DONE). Undefined: ACCESS waits indefinitely; no counter logic.

Decomposition:
Shared package pr_bridge_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2, ERR=2'd3), DEV0_BASE/DEV1_BASE defaults, device index constants. One sub-module natural: pr_addr_dec (combinational window decoder, outputs hit0/hit1/dev_addr), instantiated once.

Test Plan:
- Read dev0 0x7F04, dev_ack[0] in first ACCESS cycle, dev_rdata0=32'hDEAD_BEEF -> dev_req=2'b01, dev_addr=1, cpu_ready 2 cycles after IDLE sample, cpu_rdata=32'hDEAD_BEEF.
- Write dev1 0x7F18 data 32'h0000_0009, ack after 3 wait cycles -> dev_req=2'b10, dev_we=1, dev_wdata=9, dev_addr=2 held 4 cycles, single cpu_ready pulse.
- Access 0x7F0C and 0x7F20 -> no dev_req, cpu_ready with cpu_rdata=0, bus_err=1; err_clr pulse -> bus_err=0; concurrent ERR+err_clr -> bus_err=1.
- Back-to-back: cpu_req held through completion -> second access starts from IDLE, dev_ack[1] during dev0 access ignored.
- dev_irq=2'b10 -> hwint=6'b000010 one cycle later; rst=0 during ACCESS -> dev_req=0 immediately, no cpu_ready.
- TIMEOUT_EN, TIMEOUT=16, no ack -> ERR after 16 ACCESS cycles, bus_err=1; ack on 16th cycle -> DONE, bus_err=0.
